seg_display_scan: RTL and testbench

//  Parametrised multiplexed 7-segment scanner for the RGB LED driver front panel.

---
 rtl/seg_pkg.sv | 66 ++++++
 rtl/bin2bcd_seq.sv | 88 ++++++++
 rtl/seg_display_scan.sv | 142 ++++++++++++++
 tb/tb_seg_display_scan.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scanner: glyph table, buffer digit codes
// and the double-dabble sequencer state type.
package seg_pkg;

  localparam logic [7:0] GLYPH_DASH  = 8'hFD;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_E     = 8'h61;

  typedef enum logic [1:0] {
    DC_HEX,
    DC_DASH,
    DC_BLANK,
    DC_ERR
  } digit_kind_e;

  typedef struct packed {
    digit_kind_e kind;
    logic [3:0]  val;
  } digit_code_t;

  localparam digit_code_t CODE_DASH  = '{kind: DC_DASH,  val: 4'd0};
  localparam digit_code_t CODE_BLANK = '{kind: DC_BLANK, val: 4'd0};
  localparam digit_code_t CODE_ERR   = '{kind: DC_ERR,   val: 4'd0};

  typedef enum logic [1:0] {
    BCD_IDLE,
    BCD_SHIFT,
    BCD_DONE
  } bcd_state_e;

  function automatic digit_code_t hex_code(input logic [3:0] v);
    return '{kind: DC_HEX, val: v};
  endfunction

  // Active-low {a,b,c,d,e,f,g,dp}
  function automatic logic [7:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: return 8'h03;
      4'h1: return 8'h9F;
      4'h2: return 8'h25;
      4'h3: return 8'h0D;
      4'h4: return 8'h99;
      4'h5: return 8'h49;
      4'h6: return 8'h41;
      4'h7: return 8'h1F;
      4'h8: return 8'h01;
      4'h9: return 8'h09;
      4'hA: return 8'h11;
      4'hB: return 8'hC1;
      4'hC: return 8'h63;
      4'hD: return 8'h85;
      4'hE: return 8'h61;
      default: return 8'h71;
    endcase
  endfunction

  function automatic logic [7:0] code_glyph(input digit_code_t dc);
    case (dc.kind)
      DC_HEX:  return glyph(dc.val);
      DC_DASH: return GLYPH_DASH;
      DC_ERR:  return GLYPH_E;
      default: return GLYPH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one shift per clock.
//  state     | meaning
//  BCD_IDLE  | waiting for START, BIN captured on the START edge
//  BCD_SHIFT | one adjust+shift per CLK, DUTY_W cycles
//  BCD_DONE  | result stable, DONE high for one cycle
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DUTY_W = 7,
  parameter int ND_V   = 3
) (
  input  logic                CLK,
  input  logic                CLR_N,
  input  logic                START,
  input  logic [DUTY_W-1:0]   BIN,
  output logic                BUSY,
  output logic                DONE,
  output logic [4*ND_V-1:0]   BCD,
  output logic                OVF
);

  // Three binary bits never need more than one decimal digit.
  localparam int ND_I  = (DUTY_W + 2) / 3;
  localparam int ND_W  = (ND_I > ND_V) ? ND_I : ND_V;
  localparam int CNT_W = $clog2(DUTY_W + 1);

  bcd_state_e          state, state_nxt;
  logic [DUTY_W-1:0]   bin_sr;
  logic [4*ND_W-1:0]   bcd_sr;
  logic [4*ND_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]    cnt;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) state <= BCD_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BCD_IDLE:  if (START) state_nxt = BCD_SHIFT;
      BCD_SHIFT: if (cnt == '0) state_nxt = BCD_DONE;
      BCD_DONE:  state_nxt = BCD_IDLE;
      default:   state_nxt = BCD_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_sr;
    for (int d = 0; d < ND_W; d++) begin
      if (bcd_sr[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        BCD_IDLE: if (START) begin
          bin_sr <= BIN;
          bcd_sr <= '0;
          cnt    <= CNT_W'(DUTY_W - 1);
        end
        BCD_SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
          cnt              <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state != BCD_IDLE);
  assign DONE = (state == BCD_DONE);
  assign BCD  = bcd_sr[4*ND_V-1:0];

  generate
    if (ND_W > ND_V) begin : g_ovf
      assign OVF = |bcd_sr[4*ND_W-1:4*ND_V];
    end else begin : g_no_ovf
      assign OVF = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed 7-segment scanner: channel index, '-', and the channel's duty in
// decimal with leading-zero blanking, overflow 'E' and optional value blinking.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int  N_DIGITS    = 5,
  parameter int  N_CH        = 3,
  parameter int  DUTY_W      = 7,
  parameter int  BLINK_TICKS = 256,
  localparam int CH_W        = $clog2(N_CH + 1)
) (
  input  logic                     CLK,
  input  logic                     CLR_N,
  input  logic                     CE_IN,
  input  logic [CH_W-1:0]          SEL,
  input  logic [N_CH*DUTY_W-1:0]   DUTY_BUS,
  input  logic                     BLINK_EN,
  output logic [N_DIGITS-1:0]      SEG,
  output logic [7:0]               DISP,
  output logic                     BUSY
);

  localparam int ND_V  = N_DIGITS - 2;
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int BT_W  = $clog2(BLINK_TICKS + 1);

  logic [CH_W-1:0]     sel_eff;
  logic [DUTY_W-1:0]   duty_sel;
  logic [CH_W-1:0]     lat_sel;
  logic [DUTY_W-1:0]   lat_val;
  logic                start;
  logic                bcd_done;
  logic [4*ND_V-1:0]   bcd;
  logic                ovf;

  logic [IDX_W-1:0]    scan_idx;
  logic [BT_W-1:0]     blink_cnt;
  logic                phase_on;

  digit_code_t         disp_buf   [N_DIGITS];
  digit_code_t         commit_buf [N_DIGITS];
  logic [3:0]          nib;
  logic                lz_seen;

  function automatic digit_code_t init_code(input int i);
    if (i == 1)                      return CODE_DASH;
    if (i == 0 || i == N_DIGITS - 1) return hex_code(4'd0);
    return CODE_BLANK;
  endfunction

  always_comb begin
    sel_eff  = (int'(SEL) > N_CH) ? '0 : SEL;
    duty_sel = '0;
    for (int k = 1; k <= N_CH; k++) begin
      if (sel_eff == CH_W'(k)) duty_sel = DUTY_BUS[k*DUTY_W-1 -: DUTY_W];
    end
  end

  assign start = !BUSY && ((sel_eff != lat_sel) || (duty_sel != lat_val));

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      lat_sel <= '0;
      lat_val <= '0;
    end else if (start) begin
      lat_sel <= sel_eff;
      lat_val <= duty_sel;
    end
  end

  bin2bcd_seq #(
    .DUTY_W (DUTY_W),
    .ND_V   (ND_V)
  ) u_bcd (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .START (start),
    .BIN   (duty_sel),
    .BUSY  (BUSY),
    .DONE  (bcd_done),
    .BCD   (bcd),
    .OVF   (ovf)
  );

  // Whole buffer image built from the finished result, so a commit is atomic.
  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) commit_buf[i] = CODE_BLANK;
    commit_buf[0] = hex_code(4'(lat_sel));
    commit_buf[1] = CODE_DASH;
    nib     = '0;
    lz_seen = 1'b0;
    for (int j = ND_V - 1; j >= 0; j--) begin
      nib = bcd[4*j +: 4];
      if (ovf)                               commit_buf[N_DIGITS-1-j] = CODE_ERR;
      else if (nib != '0 || lz_seen || j == 0) commit_buf[N_DIGITS-1-j] = hex_code(nib);
      lz_seen = lz_seen | (nib != '0);
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      for (int i = 0; i < N_DIGITS; i++) disp_buf[i] <= init_code(i);
    end else if (bcd_done) begin
      disp_buf <= commit_buf;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N)                                   scan_idx <= '0;
    else if (CE_IN && scan_idx == IDX_W'(N_DIGITS - 1)) scan_idx <= '0;
    else if (CE_IN)                               scan_idx <= scan_idx + 1'b1;
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      blink_cnt <= BT_W'(BLINK_TICKS - 1);
      phase_on  <= 1'b1;
    end else if (!BLINK_EN) begin
      blink_cnt <= BT_W'(BLINK_TICKS - 1);
      phase_on  <= 1'b1;
    end else if (CE_IN) begin
      if (blink_cnt == '0) begin
        blink_cnt <= BT_W'(BLINK_TICKS - 1);
        phase_on  <= ~phase_on;
      end else begin
        blink_cnt <= blink_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      SEG  <= '1;
      DISP <= GLYPH_BLANK;
    end else if (CE_IN) begin
      SEG <= ~(N_DIGITS'(1) << scan_idx);
      if (scan_idx >= IDX_W'(2) && BLINK_EN && !phase_on) DISP <= GLYPH_BLANK;
      else                                                DISP <= code_glyph(disp_buf[scan_idx]);
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: a 5-digit/3-channel and a 4-digit/4-channel
// instance driven with directed and random stimulus against an arithmetic model.
module tb_seg_display_scan;

  logic        clk = 1'b0;
  logic        clr_n, ce_in, blink_en;
  logic [1:0]  sel_a;
  logic [2:0]  sel_b;
  logic [20:0] duty_bus_a;
  logic [27:0] duty_bus_b;
  logic [4:0]  seg_a;
  logic [3:0]  seg_b;
  logic [7:0]  disp_a, disp_b;
  logic        busy_a, busy_b;

  always #5 clk = ~clk;

  seg_display_scan #(.N_DIGITS(5), .N_CH(3), .DUTY_W(7), .BLINK_TICKS(4)) u_a (
    .CLK(clk), .CLR_N(clr_n), .CE_IN(ce_in), .SEL(sel_a), .DUTY_BUS(duty_bus_a),
    .BLINK_EN(blink_en), .SEG(seg_a), .DISP(disp_a), .BUSY(busy_a));

  seg_display_scan #(.N_DIGITS(4), .N_CH(4), .DUTY_W(7), .BLINK_TICKS(4)) u_b (
    .CLK(clk), .CLR_N(clr_n), .CE_IN(ce_in), .SEL(sel_b), .DUTY_BUS(duty_bus_b),
    .BLINK_EN(blink_en), .SEG(seg_b), .DISP(disp_b), .BUSY(busy_b));

  int checks = 0;
  int errors = 0;
  int duty_a [1:3];
  int duty_b [1:4];
  int lat_sel_a, lat_val_a, lat_sel_b, lat_val_b;
  int shw_sel_a, shw_val_a, shw_sel_b, shw_val_b;
  int idx_a, idx_b, bcnt;

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] hex_glyph(input int v);
    case (v)
      0: return 8'h03;  1: return 8'h9F;  2: return 8'h25;  3: return 8'h0D;
      4: return 8'h99;  5: return 8'h49;  6: return 8'h41;  7: return 8'h1F;
      8: return 8'h01;  9: return 8'h09; 10: return 8'h11; 11: return 8'hC1;
      12: return 8'h63; 13: return 8'h85; 14: return 8'h61; default: return 8'h71;
    endcase
  endfunction

  // Expected glyph at position pos of an nd-digit panel showing (sel, val).
  function automatic logic [7:0] exp_disp(input int nd, input int pos, input int sel,
                                          input int val, input bit on);
    int j;
    if (pos == 0) return hex_glyph(sel);
    if (pos == 1) return 8'hFD;
    if (!on) return 8'hFF;
    if (val >= pow10(nd - 2)) return 8'h61;
    j = nd - 1 - pos;
    if (j > 0 && val < pow10(j)) return 8'hFF;
    return hex_glyph((val / pow10(j)) % 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 1; k <= 3; k++) duty_bus_a[k*7-1 -: 7] = 7'(duty_a[k]);
    for (int k = 1; k <= 4; k++) duty_bus_b[k*7-1 -: 7] = 7'(duty_b[k]);
  endtask

  task automatic model_reset();
    lat_sel_a = 0; lat_val_a = 0; lat_sel_b = 0; lat_val_b = 0;
    shw_sel_a = 0; shw_val_a = 0; shw_sel_b = 0; shw_val_b = 0;
    idx_a = 0; idx_b = 0; bcnt = 0;
  endtask

  task automatic wait_idle(input string tag, output int na, output int nb);
    bit done = 1'b0;
    na = 0; nb = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (busy_a) na++;
      if (busy_b) nb++;
      if (!busy_a && !busy_b) done = 1'b1;
    end
    chk({tag, " settled"}, 32'(done), 32'd1);
  endtask

  // Inputs were just driven at a negedge: expect a full conversion wherever the pair changed.
  task automatic settle(input string tag);
    int na, nb, sa, va, sb, vb;
    sa = int'(sel_a);
    va = (sa == 0) ? 0 : duty_a[sa];
    sb = (int'(sel_b) > 4) ? 0 : int'(sel_b);
    vb = (sb == 0) ? 0 : duty_b[sb];
    wait_idle(tag, na, nb);
    chk({tag, " busy_a cycles"}, 32'(na), (sa != lat_sel_a || va != lat_val_a) ? 32'd8 : 32'd0);
    chk({tag, " busy_b cycles"}, 32'(nb), (sb != lat_sel_b || vb != lat_val_b) ? 32'd8 : 32'd0);
    lat_sel_a = sa; lat_val_a = va; lat_sel_b = sb; lat_val_b = vb;
    shw_sel_a = sa; shw_val_a = va; shw_sel_b = sb; shw_val_b = vb;
  endtask

  task automatic tick();
    bit on;
    ce_in = 1'b1;
    @(negedge clk);
    ce_in = 1'b0;
    on = blink_en ? (((bcnt / 4) % 2) == 0) : 1'b1;
    chk("seg_a",  32'(seg_a),  32'(31 ^ (1 << idx_a)));
    chk("disp_a", 32'(disp_a), 32'(exp_disp(5, idx_a, shw_sel_a, shw_val_a, on)));
    chk("seg_b",  32'(seg_b),  32'(15 ^ (1 << idx_b)));
    chk("disp_b", 32'(disp_b), 32'(exp_disp(4, idx_b, shw_sel_b, shw_val_b, on)));
    idx_a = (idx_a + 1) % 5;
    idx_b = (idx_b + 1) % 4;
    if (blink_en) bcnt++;
    else          bcnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " seg_a"},  32'(seg_a),  32'h1F);
    chk({tag, " disp_a"}, 32'(disp_a), 32'hFF);
    chk({tag, " busy_a"}, 32'(busy_a), 32'd0);
    chk({tag, " seg_b"},  32'(seg_b),  32'hF);
    chk({tag, " disp_b"}, 32'(disp_b), 32'hFF);
    chk({tag, " busy_b"}, 32'(busy_b), 32'd0);
  endtask

  initial begin
    int na, nb;
    clr_n = 1'b0; ce_in = 1'b0; blink_en = 1'b0;
    sel_a = '0; sel_b = '0; duty_bus_a = '0; duty_bus_b = '0;
    for (int k = 1; k <= 3; k++) duty_a[k] = 0;
    for (int k = 1; k <= 4; k++) duty_b[k] = 0;
    drive();
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    clr_n = 1'b1;

    // Reset buffer scan with nothing selected.
    settle("idle");
    repeat (5) tick();

    // Three-digit value then a single digit; 100 overflows the 2-digit panel.
    sel_a = 2'd1; duty_a[1] = 100; sel_b = 3'd1; duty_b[1] = 100; drive();
    settle("red100");
    repeat (20) tick();
    duty_a[1] = 7; duty_b[1] = 7; drive();
    settle("red7");
    repeat (20) tick();

    sel_a = 2'd3; duty_a[3] = 100; sel_b = 3'd3; duty_b[3] = 100; drive();
    settle("blue100");
    repeat (20) tick();
    duty_a[3] = 99; duty_b[3] = 99; drive();
    settle("blue99");
    repeat (20) tick();

    // Selection change while busy: first result lands, second starts one cycle later.
    sel_a = 2'd1; duty_a[1] = 55; sel_b = 3'd1; duty_b[1] = 42; drive();
    repeat (3) @(negedge clk);
    sel_a = 2'd2; duty_a[2] = 88; sel_b = 3'd2; duty_b[2] = 7; drive();
    wait_idle("mid_busy", na, nb);
    chk("mid_busy busy_a rest", 32'(na), 32'd5);
    chk("mid_busy busy_b rest", 32'(nb), 32'd5);
    @(negedge clk);
    chk("restart busy_a", 32'(busy_a), 32'd1);
    chk("restart busy_b", 32'(busy_b), 32'd1);
    shw_sel_a = 1; shw_val_a = 55; shw_sel_b = 1; shw_val_b = 42;
    repeat (5) tick();
    wait_idle("second", na, nb);
    chk("second busy_a rest", 32'(na), 32'd2);
    chk("second busy_b rest", 32'(nb), 32'd2);
    lat_sel_a = 2; lat_val_a = 88; lat_sel_b = 2; lat_val_b = 7;
    shw_sel_a = 2; shw_val_a = 88; shw_sel_b = 2; shw_val_b = 7;
    repeat (20) tick();

    // Blinking value digits.
    blink_en = 1'b1;
    repeat (20) tick();
    blink_en = 1'b0;
    repeat (5) tick();

    // Random selections and duties, with occasional unchanged inputs and blinking.
    for (int it = 0; it < 25; it++) begin
      sel_a = 2'($urandom_range(0, 3));
      sel_b = 3'($urandom_range(0, 7));
      if (it % 4 != 3) begin
        for (int k = 1; k <= 3; k++) duty_a[k] = $urandom_range(0, 127);
        for (int k = 1; k <= 4; k++) duty_b[k] = $urandom_range(0, 127);
      end
      blink_en = ($urandom_range(0, 3) == 0);
      drive();
      settle("random");
      repeat (20) tick();
    end
    blink_en = 1'b0;

    // Async reset in the middle of a scan and a conversion.
    repeat (2) tick();
    sel_a = 2'((lat_sel_a % 3) + 1);
    sel_b = 3'((lat_sel_b % 4) + 1);
    duty_a[int'(sel_a)] = $urandom_range(0, 127);
    duty_b[int'(sel_b)] = $urandom_range(0, 127);
    drive();
    repeat (3) @(negedge clk);
    chk("pre_reset busy_a", 32'(busy_a), 32'd1);
    #2 clr_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    clr_n = 1'b1;
    model_reset();
    settle("post_reset");
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
